// File: rtl/spike_matvec.sv
// Spiking mat-vec: I[r] = sum_c W[r][c] * s[c], one signed current per row to dest memory.
// Optional SPIKE_MATVEC_SATURATE_EN clamps each current to the signed DATA_W range instead of wrapping.
module spike_matvec #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int DIM_W  = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [DIM_W-1:0]  row_size,
    input  logic [DIM_W-1:0]  col_size,
    input  logic [ADDR_W-1:0] src1_start_address,
    output logic [ADDR_W-1:0] src1_address,
    input  logic [DATA_W-1:0] src1_readdata,
    input  logic [ADDR_W-1:0] src2_start_address,
    output logic [ADDR_W-1:0] src2_address,
    input  logic [DATA_W-1:0] src2_readdata,
    input  logic [ADDR_W-1:0] dest_start_address,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_writedata,
    output logic              dest_write_en
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRITE} state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0]        row, col;
    logic [ADDR_W-1:0]       row_off;
    logic signed [ACC_W-1:0] acc, acc_add;
    logic                    rd_pend;
    logic                    sizes_ok, last_col, last_row, wr;
    logic [DATA_W-1:0]       result;

    assign sizes_ok = (row_size != '0) && (col_size != '0);
    assign last_col = (col == col_size - DIM_W'(1));
    assign last_row = (row == row_size - DIM_W'(1));

    // Spike bit gates the sign-extended weight; upper spike-word bits are don't-care.
    assign acc_add = src2_readdata[0] ? ACC_W'($signed(src1_readdata)) : '0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && sizes_ok) state_nxt = RUN;
            RUN:     if (last_col) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = last_row ? IDLE : RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            row_off <= '0;
            acc     <= '0;
            rd_pend <= 1'b0;
        end else begin
            // Read data lags the address by one cycle, so track what was issued.
            rd_pend <= (state == RUN);
            case (state)
                IDLE: if (start && sizes_ok) begin
                    row     <= '0;
                    col     <= '0;
                    row_off <= '0;
                    acc     <= '0;
                end
                RUN: begin
                    if (rd_pend)   acc <= acc + acc_add;
                    if (!last_col) col <= col + DIM_W'(1);
                end
                DRAIN: if (rd_pend) acc <= acc + acc_add;
                WRITE: begin
                    acc <= '0;
                    col <= '0;
                    if (last_row) begin
                        row     <= '0;
                        row_off <= '0;
                    end else begin
                        row     <= row + DIM_W'(1);
                        row_off <= row_off + ADDR_W'(col_size);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPIKE_MATVEC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (DATA_W - 1));

    always_comb begin
        result = acc[DATA_W-1:0];
        if (acc > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
        else if (acc < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, src2_readdata[DATA_W-1:1]};
`else
    assign result = acc[DATA_W-1:0];

    logic unused_ok;
    assign unused_ok = &{1'b0, src2_readdata[DATA_W-1:1], acc[ACC_W-1:DATA_W]};
`endif

    // Strobe is gated by reset so an aborted job never writes on the reset cycle.
    assign wr             = (state == WRITE) && !reset;
    assign dest_write_en  = wr;
    assign dest_writedata = wr ? result : '0;
    assign done           = (state == IDLE);

    // Counters sit at zero in IDLE, so addresses track the start addresses there.
    assign src1_address = src1_start_address + row_off + ADDR_W'(col);
    assign src2_address = src2_start_address + ADDR_W'(col);
    assign dest_address = dest_start_address + ADDR_W'(row);

endmodule

// File: tb/tb_spike_matvec.sv
// Self-checking bench for spike_matvec: random jobs against an arithmetic reference model.
// Honors SPIKE_MATVEC_SATURATE_EN the same way as the design.
module tb_spike_matvec;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int DIM_W  = 10;
    localparam int MEM    = 1 << ADDR_W;

    logic              clk, reset, start, done;
    logic [DIM_W-1:0]  row_size, col_size;
    logic [ADDR_W-1:0] src1_start_address, src1_address;
    logic [ADDR_W-1:0] src2_start_address, src2_address;
    logic [ADDR_W-1:0] dest_start_address, dest_address;
    logic [DATA_W-1:0] src1_readdata, src2_readdata, dest_writedata;
    logic              dest_write_en;

    spike_matvec dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .row_size(row_size), .col_size(col_size),
        .src1_start_address(src1_start_address), .src1_address(src1_address),
        .src1_readdata(src1_readdata),
        .src2_start_address(src2_start_address), .src2_address(src2_address),
        .src2_readdata(src2_readdata),
        .dest_start_address(dest_start_address), .dest_address(dest_address),
        .dest_writedata(dest_writedata), .dest_write_en(dest_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem1 [MEM];
    logic [DATA_W-1:0] mem2 [MEM];

    always @(posedge clk) begin
        src1_readdata <= mem1[src1_address];
        src2_readdata <= mem2[src2_address];
    end

    logic [ADDR_W-1:0] wq_a [$];
    logic [DATA_W-1:0] wq_d [$];

    always @(negedge clk) begin
        if (dest_write_en === 1'b1) begin
            wq_a.push_back(dest_address);
            wq_d.push_back(dest_writedata);
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic logic [DATA_W-1:0] model(int r, int cols, int b1, int b2);
        longint acc = 0;
        for (int c = 0; c < cols; c++) begin
            logic [DATA_W-1:0] s;
            logic signed [DATA_W-1:0] w;
            s = mem2[(b2 + c) % MEM];
            w = mem1[(b1 + r * cols + c) % MEM];
            if (s[0]) acc += longint'(w);
        end
`ifdef SPIKE_MATVEC_SATURATE_EN
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`endif
        return acc[DATA_W-1:0];
    endfunction

    task automatic fill_rand(int b1, int b2, int rows, int cols, bit spikes);
        for (int i = 0; i < rows * cols; i++) mem1[(b1 + i) % MEM] = DATA_W'($urandom);
        for (int c = 0; c < cols; c++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'($urandom);
            v[0] = spikes ? v[0] : 1'b0;
            mem2[(b2 + c) % MEM] = v;
        end
    endtask

    task automatic set_job(int rows, int cols, int b1, int b2, int bd);
        row_size = DIM_W'(rows);
        col_size = DIM_W'(cols);
        src1_start_address = ADDR_W'(b1);
        src2_start_address = ADDR_W'(b2);
        dest_start_address = ADDR_W'(bd);
    endtask

    task automatic run_job(int rows, int cols, int b1, int b2, int bd, bit extra_start,
                           output int busy);
        set_job(rows, cols, b1, b2, bd);
        wq_a.delete();
        wq_d.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy = 0;
        while (done !== 1'b1 && busy < 5000) begin
            busy++;
            start = (extra_start && busy == 2);
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        if (busy != rows * (cols + 2))
            $display("FAIL busy_cycles %0dx%0d: got %0d want %0d", rows, cols, busy, rows * (cols + 2));
        if (busy != rows * (cols + 2)) bad++;
    endtask

    task automatic check_writes(string name, int rows, int cols, int b1, int b2, int bd);
        total++;
        if (wq_a.size() != rows) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", name, wq_a.size(), rows);
        end
        for (int r = 0; r < rows && r < wq_a.size(); r++) begin
            logic [ADDR_W-1:0] ea;
            logic [DATA_W-1:0] ed;
            ea = ADDR_W'((bd + r) % MEM);
            ed = model(r, cols, b1, b2);
            total++;
            if (wq_a[r] !== ea || wq_d[r] !== ed) begin
                bad++;
                $display("FAIL %s row%0d: got addr %0d data %h want addr %0d data %h",
                         name, r, wq_a[r], wq_d[r], ea, ed);
            end
        end
    endtask

    task automatic check_idle_outputs(string name);
        total++;
        if (done !== 1'b1 || dest_write_en !== 1'b0 || dest_writedata !== '0 ||
            src1_address !== src1_start_address || src2_address !== src2_start_address ||
            dest_address !== dest_start_address) begin
            bad++;
            $display("FAIL %s idle_outputs: got done=%b we=%b wd=%h a1=%0d a2=%0d ad=%0d want 1 0 0 %0d %0d %0d",
                     name, done, dest_write_en, dest_writedata, src1_address, src2_address,
                     dest_address, src1_start_address, src2_start_address, dest_start_address);
        end
    endtask

    task automatic test_reset();
        set_job(2, 3, 37, 91, 555);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        int busy;
        logic [DATA_W-1:0] w [6] = '{16'd1, 16'd2, 16'd3, 16'hFFFC, 16'd5, 16'hFFFA};
        for (int i = 0; i < 6; i++) mem1[100 + i] = w[i];
        mem2[200] = 16'h0001;
        mem2[201] = 16'hFFFE;
        mem2[202] = 16'h8003;
        run_job(2, 3, 100, 200, 300, 1'b0, busy);
        check_writes("basic", 2, 3, 100, 200, 300);
        total++;
        if (wq_d.size() != 2 || wq_d[0] !== 16'd4 || wq_d[1] !== 16'hFFF6) begin
            bad++;
            $display("FAIL basic_const: got %0d writes, first values %h %h want 0004 fff6",
                     wq_d.size(), wq_d.size() > 0 ? wq_d[0] : 16'hx, wq_d.size() > 1 ? wq_d[1] : 16'hx);
        end
    endtask

    task automatic test_overflow();
        int busy;
        logic [DATA_W-1:0] exp_v;
        for (int i = 0; i < 4; i++) begin
            mem1[400 + i] = 16'h7FFF;
            mem2[500 + i] = 16'h0001;
        end
`ifdef SPIKE_MATVEC_SATURATE_EN
        exp_v = 16'h7FFF;
`else
        exp_v = 16'hFFFC;
`endif
        run_job(1, 4, 400, 500, 600, 1'b0, busy);
        total++;
        if (wq_d.size() != 1 || wq_d[0] !== exp_v) begin
            bad++;
            $display("FAIL overflow: got %0d writes value %h want 1 write %h",
                     wq_d.size(), wq_d.size() > 0 ? wq_d[0] : 16'hx, exp_v);
        end
    endtask

    task automatic test_zero_spikes();
        int busy;
        fill_rand(1000, 1100, 4, 4, 1'b0);
        run_job(4, 4, 1000, 1100, 1200, 1'b0, busy);
        total++;
        if (wq_d.size() != 4 || wq_d.sum() with (int'(item != 0)) != 0 || done !== 1'b1) begin
            bad++;
            $display("FAIL zero_spikes: got %0d writes done=%b want 4 zero writes done=1",
                     wq_d.size(), done);
        end
        check_writes("zero_spikes", 4, 4, 1000, 1100, 1200);
    endtask

    task automatic test_zero_size();
        for (int k = 0; k < 2; k++) begin
            set_job(k == 0 ? 0 : 3, k == 0 ? 3 : 0, 2000, 2100, 2200);
            wq_a.delete();
            wq_d.delete();
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            repeat (5) begin
                check_idle_outputs(k == 0 ? "zero_rows" : "zero_cols");
                @(negedge clk);
            end
            total++;
            if (wq_a.size() != 0) begin
                bad++;
                $display("FAIL zero_size%0d writes: got %0d want 0", k, wq_a.size());
            end
        end
    endtask

    task automatic test_random();
        int busy;
        for (int it = 0; it < 8; it++) begin
            int rows, cols, b1, b2, bd;
            rows = $urandom_range(1, 6);
            cols = $urandom_range(1, 9);
            b1 = (it % 3 == 0) ? MEM - $urandom_range(1, 10) : $urandom_range(0, MEM - 1);
            b2 = $urandom_range(0, MEM - 1);
            bd = (it % 2 == 0) ? MEM - 2 : $urandom_range(0, MEM - 1);
            if (((b2 - b1 + MEM) % MEM) < 64) b2 = (b1 + 100) % MEM;
            fill_rand(b1, b2, rows, cols, 1'b1);
            run_job(rows, cols, b1, b2, bd, 1'b0, busy);
            check_writes("random", rows, cols, b1, b2, bd);
        end
    endtask

    task automatic test_reset_mid();
        int busy;
        fill_rand(3000, 3100, 3, 5, 1'b1);
        set_job(3, 5, 3000, 3100, 3200);
        wq_a.delete();
        wq_d.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_idle_outputs("reset_mid");
        repeat (8) @(negedge clk);
        total++;
        if (wq_a.size() != 1 || done !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid writes: got %0d done=%b want 1 done=1", wq_a.size(), done);
        end
        run_job(3, 5, 3000, 3100, 3200, 1'b0, busy);
        check_writes("after_reset", 3, 5, 3000, 3100, 3200);
    endtask

    task automatic test_back_to_back();
        int busy;
        int rises = 0;
        fill_rand(4000, 4100, 2, 2, 1'b1);
        run_job(2, 2, 4000, 4100, 4200, 1'b1, busy);
        repeat (6) begin
            if (done !== 1'b1) rises++;
            @(negedge clk);
        end
        total++;
        if (rises != 0 || wq_a.size() != 2) begin
            bad++;
            $display("FAIL back_to_back: got %0d writes, %0d busy cycles after done want 2 and 0",
                     wq_a.size(), rises);
        end
        check_writes("back_to_back", 2, 2, 4000, 4100, 4200);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < MEM; i++) begin
            mem1[i] = '0;
            mem2[i] = '0;
        end
        test_reset();
        test_basic();
        test_overflow();
        test_zero_spikes();
        test_zero_size();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
